// File: rtl/ttt_button_conditioner.sv
// Button front-end for the tic-tac-toe controller.
// Each of the five raw buttons is synchronized, debounced by its own small
// FSM and optionally auto-repeated. The resulting event requests are
// collected in a pending register and drained one per clock by a fixed
// priority arbiter (C > U > L > R > D), so at most one pulse is ever high.
// Vector bit order everywhere is {C,U,L,R,D}, bit 4 down to bit 0.
module ttt_button_conditioner #(
  parameter int         DB_LIMIT   = 1_000_000,
  parameter int         RPT_DELAY  = 50_000_000,
  parameter int         RPT_PERIOD = 20_000_000,
  parameter logic [4:0] RPT_MASK   = 5'b00011,
  parameter int         CNT_W      = 26
) (
  input  logic       Clk,
  input  logic       reset,
  input  logic       BtnL_raw,
  input  logic       BtnR_raw,
  input  logic       BtnU_raw,
  input  logic       BtnD_raw,
  input  logic       BtnC_raw,
  output logic       BtnL,
  output logic       BtnR,
  output logic       BtnU,
  output logic       BtnD,
  output logic       BtnC,
  output logic [4:0] Held
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HELD = 2'd1,
    ST_RELQ = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] DB_C  = CNT_W'(DB_LIMIT);
  localparam logic [CNT_W-1:0] RD_C  = CNT_W'(RPT_DELAY);
  localparam logic [CNT_W-1:0] RP_C  = CNT_W'(RPT_PERIOD);
  localparam logic [CNT_W-1:0] ONE_C = CNT_W'(1);

  logic [4:0]       raw_w;
  logic [4:0]       sync1_q, sync2_q;
  state_t           state_q [5];
  state_t           state_d [5];
  logic [CNT_W-1:0] dc_q [5];
  logic [CNT_W-1:0] dc_d [5];
  logic [CNT_W-1:0] rc_q [5];
  logic [CNT_W-1:0] rc_d [5];
  // first_q[i] = 1 while the next repeat uses the initial (longer) delay
  logic [4:0]       first_q, first_d;
  logic [4:0]       req_w;
  logic [4:0]       pend_q, pend_d;
  logic [4:0]       sel_w;
  logic [4:0]       pulse_q;

  assign raw_w = {BtnC_raw, BtnU_raw, BtnL_raw, BtnR_raw, BtnD_raw};

  // All state registers: synchronizers, per-button FSMs, pending and pulse
  always_ff @(posedge Clk or posedge reset) begin
    if (reset) begin
      sync1_q <= '0;
      sync2_q <= '0;
      first_q <= '1;
      pend_q  <= '0;
      pulse_q <= '0;
      for (int i = 0; i < 5; i++) begin
        state_q[i] <= ST_IDLE;
        dc_q[i]    <= '0;
        rc_q[i]    <= '0;
      end
    end else begin
      sync1_q <= raw_w;
      sync2_q <= sync1_q;
      first_q <= first_d;
      pend_q  <= pend_d;
      pulse_q <= sel_w;
      for (int i = 0; i < 5; i++) begin
        state_q[i] <= state_d[i];
        dc_q[i]    <= dc_d[i];
        rc_q[i]    <= rc_d[i];
      end
    end
  end

  // Per-button debounce / repeat next-state logic and event requests
  always_comb begin
    req_w   = '0;
    first_d = first_q;
    for (int i = 0; i < 5; i++) begin
      state_d[i] = state_q[i];
      dc_d[i]    = dc_q[i];
      rc_d[i]    = rc_q[i];
      case (state_q[i])
        ST_IDLE: begin
          if (sync2_q[i]) begin
            if (dc_q[i] + ONE_C == DB_C) begin
              state_d[i] = ST_HELD;
              dc_d[i]    = '0;
              rc_d[i]    = '0;
              first_d[i] = 1'b1;
              req_w[i]   = 1'b1;
            end else begin
              dc_d[i] = dc_q[i] + ONE_C;
            end
          end else begin
            dc_d[i] = '0;
          end
        end
        ST_HELD: begin
          if (sync2_q[i]) begin
            if (RPT_MASK[i] &&
                (rc_q[i] + ONE_C == (first_q[i] ? RD_C : RP_C))) begin
              req_w[i]   = 1'b1;
              rc_d[i]    = '0;
              first_d[i] = 1'b0;
            end else begin
              rc_d[i] = rc_q[i] + ONE_C;
            end
          end else begin
            // this low sample is the first one of release qualification
            state_d[i] = ST_RELQ;
            rc_d[i]    = '0;
            dc_d[i]    = ONE_C;
            first_d[i] = 1'b1;
          end
        end
        ST_RELQ: begin
          if (sync2_q[i]) begin
            state_d[i] = ST_HELD;
            dc_d[i]    = '0;
          end else if (dc_q[i] + ONE_C == DB_C) begin
            state_d[i] = ST_IDLE;
            dc_d[i]    = '0;
          end else begin
            dc_d[i] = dc_q[i] + ONE_C;
          end
        end
        default: begin
          state_d[i] = ST_IDLE;
          dc_d[i]    = '0;
          rc_d[i]    = '0;
        end
      endcase
    end
  end

  // Priority arbiter; a request on a bit being granted keeps it pending
  always_comb begin
    sel_w = '0;
    for (int i = 0; i < 5; i++) begin
      if (pend_q[i]) begin
        sel_w    = '0;
        sel_w[i] = 1'b1;
      end
    end
    pend_d = (pend_q & ~sel_w) | req_w;
  end

  // Debounced level is high whenever the button is not idle
  always_comb begin
    Held = '0;
    for (int i = 0; i < 5; i++) begin
      Held[i] = (state_q[i] != ST_IDLE);
    end
  end

  assign BtnD = pulse_q[0];
  assign BtnR = pulse_q[1];
  assign BtnL = pulse_q[2];
  assign BtnU = pulse_q[3];
  assign BtnC = pulse_q[4];

endmodule

// File: tb/tb_ttt_button_conditioner.sv
// Self-checking bench for ttt_button_conditioner: directed scenarios plus a
// randomized phase, all compared each cycle against a window/timestamp model.
module tb_ttt_button_conditioner;

  localparam int         DB   = 4;
  localparam int         RD   = 10;
  localparam int         RP   = 5;
  localparam logic [4:0] MASK = 5'b00011;

  logic       Clk = 1'b0;
  logic       reset = 1'b1;
  logic [4:0] raw = '0;   // {C,U,L,R,D}
  logic       BtnL, BtnR, BtnU, BtnD, BtnC;
  logic [4:0] Held;
  logic [4:0] pulse_o;

  assign pulse_o = {BtnC, BtnU, BtnL, BtnR, BtnD};

  ttt_button_conditioner #(
    .DB_LIMIT(DB), .RPT_DELAY(RD), .RPT_PERIOD(RP), .RPT_MASK(MASK), .CNT_W(26)
  ) dut (
    .Clk(Clk), .reset(reset),
    .BtnL_raw(raw[2]), .BtnR_raw(raw[1]), .BtnU_raw(raw[3]),
    .BtnD_raw(raw[0]), .BtnC_raw(raw[4]),
    .BtnL(BtnL), .BtnR(BtnR), .BtnU(BtnU), .BtnD(BtnD), .BtnC(BtnC),
    .Held(Held)
  );

  always #5 Clk = ~Clk;

  int checks = 0;
  int errors = 0;

  // reference model state
  logic [4:0]    m_s1, m_s2, m_lvl, m_pend, m_pulse;
  logic [DB-1:0] m_hist [5];
  bit            m_av [5];
  int            m_anchor [5];
  int            m_edge;

  task automatic chk(input string tag, input logic [4:0] got, input logic [4:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%b exp=%b t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_s1 = '0; m_s2 = '0; m_lvl = '0; m_pend = '0; m_pulse = '0;
    for (int i = 0; i < 5; i++) begin
      m_hist[i] = '0; m_av[i] = 1'b0; m_anchor[i] = 0;
    end
  endtask

  // One clock edge of the model: debounced level changes when the last DB
  // synchronized samples all disagree with it; repeats are timestamps
  // relative to the start of the current unbroken hold.
  task automatic model_step();
    logic [4:0] s, sel, req;
    int e;
    if (reset) begin
      model_reset();
    end else begin
      s = m_s2; m_s2 = m_s1; m_s1 = raw;
      sel = '0;
      for (int i = 4; i >= 0; i--) if (m_pend[i] && sel == '0) sel[i] = 1'b1;
      req = '0;
      for (int i = 0; i < 5; i++) begin
        m_hist[i] = {m_hist[i][DB-2:0], s[i]};
        if (!m_lvl[i]) begin
          if (&m_hist[i]) begin
            m_lvl[i] = 1'b1; req[i] = 1'b1; m_av[i] = 1'b1; m_anchor[i] = m_edge;
          end
        end else if (!s[i]) begin
          m_av[i] = 1'b0;
          if (m_hist[i] == '0) m_lvl[i] = 1'b0;
        end else if (!m_av[i]) begin
          m_av[i] = 1'b1; m_anchor[i] = m_edge;
        end else if (MASK[i]) begin
          e = m_edge - m_anchor[i];
          if (e >= RD && ((e - RD) % RP) == 0) req[i] = 1'b1;
        end
      end
      m_pulse = sel;
      m_pend = (m_pend & ~sel) | req;
    end
    m_edge++;
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
    model_step();
    chk("pulse", pulse_o, m_pulse);
    chk("held", Held, m_lvl);
    chk("onehot", {4'b0, ($countones(pulse_o) <= 1)}, 5'd1);
  endtask

  task automatic assert_reset();
    reset = 1'b1;
    model_reset();
    #1;
    chk("rst_async_pulse", pulse_o, 5'b0);
    chk("rst_async_held", Held, 5'b0);
  endtask

  task automatic settle(input int n);
    raw = '0;
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    int cnt;
    int rst_left;
    model_reset();
    m_edge = 0;

    // 1: reset with random raw inputs
    raw = 5'($urandom);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("reset_pulse", pulse_o, 5'b0);
      chk("reset_held", Held, 5'b0);
      raw = 5'($urandom);
    end
    raw = '0;
    reset = 1'b0;
    tick();
    chk("post_reset_pulse", pulse_o, 5'b0);
    chk("post_reset_held", Held, 5'b0);
    settle(5);

    // 2: clean press of U, 20 cycles
    raw = 5'b01000; cnt = 0;
    for (int e = 0; e < 30; e++) begin
      tick();
      if (BtnU) cnt++;
      if (e == 4)  chk("u_held_pre", Held, 5'b00000);
      if (e == 5)  chk("u_held_rise", Held, 5'b01000);
      if (e == 5)  chk("u_nopulse_5", pulse_o, 5'b00000);
      if (e == 6)  chk("u_pulse_6", pulse_o, 5'b01000);
      if (e == 7)  chk("u_nopulse_7", pulse_o, 5'b00000);
      if (e == 24) chk("u_held_24", Held, 5'b01000);
      if (e == 25) chk("u_held_fall", Held, 5'b00000);
      if (e == 19) raw = '0;
    end
    chk("u_count", 5'(cnt), 5'd1);
    settle(5);

    // 3: glitch of 3 cycles on L
    raw = 5'b00100; cnt = 0;
    for (int e = 0; e < 15; e++) begin
      tick();
      if (pulse_o != '0 || Held != '0) cnt++;
      if (e == 2) raw = '0;
    end
    chk("glitch_quiet", 5'(cnt), 5'd0);
    settle(5);

    // 4: auto-repeat on R, held edges 0..27
    raw = 5'b00010; cnt = 0;
    for (int e = 0; e < 40; e++) begin
      tick();
      if (BtnR) cnt++;
      if (e == 6 || e == 16 || e == 21 || e == 26) chk("r_rpt_pulse", pulse_o, 5'b00010);
      if (e == 15 || e == 20 || e == 31) chk("r_rpt_gap", pulse_o, 5'b00000);
      if (e == 32) chk("r_held_32", Held, 5'b00010);
      if (e == 33) chk("r_held_fall", Held, 5'b00000);
      if (e == 27) raw = '0;
    end
    chk("r_count", 5'(cnt), 5'd4);
    settle(5);

    // 5: simultaneous C and U
    raw = 5'b11000;
    for (int e = 0; e < 20; e++) begin
      tick();
      if (e == 6) chk("cu_c_first", pulse_o, 5'b10000);
      if (e == 7) chk("cu_u_second", pulse_o, 5'b01000);
      if (e == 8) chk("cu_done", pulse_o, 5'b00000);
    end
    settle(10);

    // 6: reset in the middle of a D hold
    raw = 5'b00001; cnt = 0;
    for (int e = 0; e < 4; e++) begin
      tick();
      if (pulse_o != '0) cnt++;
    end
    chk("d_prereset_quiet", 5'(cnt), 5'd0);
    assert_reset();
    for (int e = 4; e < 8; e++) tick();
    reset = 1'b0;
    cnt = 0;
    for (int e = 0; e < 11; e++) begin
      tick();
      if (BtnD) cnt++;
      if (e == 6) chk("d_fresh_pulse", pulse_o, 5'b00001);
    end
    chk("d_count", 5'(cnt), 5'd1);
    settle(10);

    // randomized phase with occasional asynchronous resets
    rst_left = 0;
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < 5; i++)
        if ($urandom_range(0, 7) == 0) raw[i] = ~raw[i];
      if (reset) begin
        rst_left--;
        if (rst_left <= 0) reset = 1'b0;
      end else if ($urandom_range(0, 499) == 0) begin
        rst_left = int'($urandom_range(1, 3));
        assert_reset();
      end
      tick();
    end
    reset = 1'b0;
    settle(10);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
